// File: rtl/axis_trigger_replay.sv
// Timestamped AXI-Stream event replay: buffers {T, D} words and drives D on dout when the run
// counter reaches T. Define AXIS_TRIGGER_REPLAY_LATE_CNT_EN to add the late_count output.
module axis_trigger_replay #(
  parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         enable,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [65:0]  dout,
  output logic         busy,
  output logic [1:0]   test
`ifdef AXIS_TRIGGER_REPLAY_LATE_CNT_EN
  ,
  output logic [15:0]  late_count
`endif
);

  localparam int unsigned Depth = 2 ** FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] PtrOne = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                   state_q, state_d;
  logic [61:0]              cnt_q, cnt_d;
  logic [65:0]              dout_q, dout_d;
  logic [FIFO_ADDR_WIDTH:0] wr_ptr_q, rd_ptr_q;
  logic [127:0]             mem_q [Depth];
  logic [127:0]             head;
  logic [61:0]              head_t;
  logic [65:0]              head_d;
  logic                     empty, full, push, pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_ADDR_WIDTH] != rd_ptr_q[FIFO_ADDR_WIDTH]) &&
                 (wr_ptr_q[FIFO_ADDR_WIDTH-1:0] == rd_ptr_q[FIFO_ADDR_WIDTH-1:0]);
  assign push  = s_axis_tvalid & ~full;

  assign head   = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];
  assign head_t = head[127:66];
  assign head_d = head[65:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = '0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) state_d = StRun;
      end
      StRun: begin
        // Matching head is replayed; a head already in the past is dropped.
        if (!empty) begin
          if (head_t == cnt_q) begin
            dout_d = head_d;
            pop    = 1'b1;
          end else if (head_t < cnt_q) begin
            pop = 1'b1;
          end
        end
        if (enable) begin
          cnt_d = cnt_q + 62'd1;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dout_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= s_axis_tdata;
  end

  assign s_axis_tready = ~full;
  assign busy          = ~empty;
  assign dout          = dout_q;
  assign test          = {dout_q[65], |dout_q[15:0]};

`ifdef AXIS_TRIGGER_REPLAY_LATE_CNT_EN
  logic        late;
  logic [15:0] late_cnt_q;

  assign late = pop && (head_t != cnt_q);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      late_cnt_q <= '0;
    end else if ((state_q == StIdle) && enable) begin
      late_cnt_q <= '0;
    end else if (late && (late_cnt_q != 16'hffff)) begin
      late_cnt_q <= late_cnt_q + 16'd1;
    end
  end

  assign late_count = late_cnt_q;
`endif

endmodule

// File: tb/tb_axis_trigger_replay.sv
// Randomised and directed bench for axis_trigger_replay against a queue-based event model.
module tb_axis_trigger_replay;

  localparam int unsigned Depth = 4;

  logic         aclk;
  logic         areset;
  logic         enable;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [65:0]  dout;
  logic         busy;
  logic [1:0]   test;
`ifdef AXIS_TRIGGER_REPLAY_LATE_CNT_EN
  logic [15:0]  late_count;
`endif

  axis_trigger_replay #(.FIFO_ADDR_WIDTH(2)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .dout          (dout),
    .busy          (busy),
    .test          (test)
`ifdef AXIS_TRIGGER_REPLAY_LATE_CNT_EN
    ,
    .late_count    (late_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: event list, run flag, time, last output, late drops.
  logic [127:0] m_q [$];
  bit           m_run;
  logic [61:0]  m_cnt;
  logic [65:0]  m_dout;
  int           m_late;

  task automatic model_reset();
    m_q.delete();
    m_run  = 1'b0;
    m_cnt  = '0;
    m_dout = '0;
    m_late = 0;
  endtask

  // One clock edge worth of behaviour, from the values present before the edge.
  task automatic model_step();
    logic [61:0] ht;
    logic        acc;
    acc    = s_axis_tvalid && (m_q.size() < Depth);
    m_dout = '0;
    if (m_run && m_q.size() > 0) begin
      ht = m_q[0][127:66];
      if (ht == m_cnt) begin
        m_dout = m_q[0][65:0];
        void'(m_q.pop_front());
      end else if (ht < m_cnt) begin
        if (m_late < 65535) m_late++;
        void'(m_q.pop_front());
      end
    end
    if (acc) m_q.push_back(s_axis_tdata);
    if (!m_run) begin
      m_cnt = '0;
      if (enable) begin
        m_run  = 1'b1;
        m_late = 0;
      end
    end else if (enable) begin
      m_cnt = m_cnt + 62'd1;
    end else begin
      m_run = 1'b0;
      m_cnt = '0;
    end
  endtask

  task automatic check_outputs();
    check("dout", 128'(dout), 128'(m_dout));
    check("busy", 128'(busy), 128'(m_q.size() != 0));
    check("tready", 128'(s_axis_tready), 128'(m_q.size() < Depth));
    check("test", 128'(test), 128'({m_dout[65], |m_dout[15:0]}));
`ifdef AXIS_TRIGGER_REPLAY_LATE_CNT_EN
    check("late_count", 128'(late_count), 128'(m_late));
`endif
  endtask

  // Inputs are applied just after a falling edge; outputs checked at the next falling edge.
  task automatic tick(input logic en, input logic vld, input logic [61:0] t,
                      input logic [65:0] d);
    enable        = en;
    s_axis_tvalid = vld;
    s_axis_tdata  = {t, d};
    model_step();
    @(negedge aclk);
    check_outputs();
  endtask

  task automatic idle_ticks(input logic en, input int n);
    for (int i = 0; i < n; i++) tick(en, 1'b0, '0, '0);
  endtask

  task automatic async_reset();
    enable        = 1'b0;
    s_axis_tvalid = 1'b0;
    #2 areset = 1'b1;
    #1;
    model_reset();
    check("rst_dout", 128'(dout), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_test", 128'(test), 128'd0);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  logic [95:0] rnd;
  logic [61:0] rt;
  logic [65:0] rd;
  logic        ren;

  initial begin
    areset        = 1'b1;
    enable        = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    model_reset();
    repeat (2) @(negedge aclk);
    check_outputs();
    areset = 1'b0;
    @(negedge aclk);
    check_outputs();

    // Single event queued while idle, then played.
    tick(1'b0, 1'b1, 62'd5, 66'h1);
    idle_ticks(1'b1, 10);
    idle_ticks(1'b0, 2);

    // Back-pressure: five words with enable low, fifth waits for a pop.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 62'(i + 1), 66'(i + 7));
    tick(1'b0, 1'b1, 62'd5, 66'd11);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 62'd5, 66'd11);
    idle_ticks(1'b1, 4);
    idle_ticks(1'b0, 2);

    // Late event dropped once the counter is well past it.
    idle_ticks(1'b1, 100);
    tick(1'b1, 1'b1, 62'd50, {66{1'b1}});
    idle_ticks(1'b1, 3);
    idle_ticks(1'b0, 2);

    // Back-to-back events on consecutive counts, including a zero pattern.
    tick(1'b0, 1'b1, 62'd10, 66'd1);
    tick(1'b0, 1'b1, 62'd11, 66'd2);
    tick(1'b0, 1'b1, 62'd12, 66'd3);
    tick(1'b0, 1'b1, 62'd13, 66'd0);
    idle_ticks(1'b1, 18);

    // Enable dropped and restored with an event pending.
    idle_ticks(1'b0, 2);
    tick(1'b0, 1'b1, 62'd20, 66'h2_0000_0000_0000_0000);
    idle_ticks(1'b1, 8);
    idle_ticks(1'b0, 3);
    idle_ticks(1'b1, 25);
    idle_ticks(1'b0, 2);

    // Reset mid-playback with events still queued.
    tick(1'b0, 1'b1, 62'd30, 66'd4);
    tick(1'b0, 1'b1, 62'd31, 66'd5);
    tick(1'b0, 1'b1, 62'd32, 66'd6);
    idle_ticks(1'b1, 10);
    async_reset();
    check_outputs();
    idle_ticks(1'b1, 40);
    idle_ticks(1'b0, 2);

    // Random traffic around the running counter.
    ren = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) ren = ~ren;
      rnd = {$urandom(), $urandom(), $urandom()};
      rd  = ($urandom_range(0, 9) == 0) ? 66'd0 : rnd[65:0];
      if ($urandom_range(0, 4) == 0 && m_cnt >= 62'd3)
        rt = m_cnt - 62'($urandom_range(0, 3));
      else
        rt = m_cnt + 62'($urandom_range(0, 8));
      tick(ren, ($urandom_range(0, 9) < 4), rt, rd);
      if (i == 300) begin
        async_reset();
        check_outputs();
      end
    end
    idle_ticks(1'b1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
